// File: rtl/msu_audio_streamer.sv
// MSU-1 PCM sector streamer: fetches SD sectors, parses the header and writes only in-range sample words to the audio FIFO.
// Samples appear 1 cycle after sd_buff_wr; MSU_SIG_CHECK_EN adds the "MSU1" signature check.
module msu_audio_streamer #(
    parameter int SECTOR_WORDS = 256,
    parameter int LBA_W        = 21,
    parameter int FIFO_AW      = 12,
    parameter int FIFO_HIGH    = 1792,
    parameter int HDR_WORDS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        img_size,
    input  logic               trackmounting,
    input  logic               trackmissing,
    input  logic               trig_play,
    input  logic               trig_pause,
    input  logic               trig_stop,
    input  logic               repeat_in,
    input  logic               sd_ack,
    input  logic               sd_buff_wr,
    input  logic [15:0]        sd_buff_dout,
    input  logic [FIFO_AW-1:0] audio_fifo_usedw,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sample_wr,
    output logic [15:0]        sample_data,
    output logic               audio_play,
    output logic               track_end,
    output logic               header_bad
);
    localparam int WI = $clog2(SECTOR_WORDS);
    localparam logic [31:0] HDR32    = 32'(HDR_WORDS);
    localparam logic [31:0] SEC32    = 32'(SECTOR_WORDS);
    localparam logic [31:0] HIGH32   = 32'(FIFO_HIGH);
    localparam logic [31:0] MIN_SIZE = 32'(2 * HDR_WORDS + 2);
`ifdef MSU_SIG_CHECK_EN
    localparam bit SIG_CHECK = 1'b1;
`else
    localparam bit SIG_CHECK = 1'b0;
`endif
    localparam logic [1:0] P_NONE = 2'd0, P_PLAY = 2'd1, P_PAUSE = 2'd2, P_STOP = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_WAIT, S_END, S_PAUSED} state_t;
    typedef enum logic [3:0] {A_NONE, A_START, A_EMPTY, A_REQ, A_XFER, A_RESTART, A_STOP, A_PAUSE,
                              A_PAUSE_NEXT, A_NEXT, A_RESUME, A_LOOP, A_FINISH, A_SIGBAD} act_t;

    state_t          state, state_next;
    act_t            act;
    logic [WI-1:0]   word_idx;
    logic [31:0]     start_addr, loop_addr, last, lba_base, addr;
    logic [15:0]     loop_lo;
    logic [1:0]      pend, trig_code, pend_eff;
    logic            sig_bad, past_last, fifo_ok;
    logic [33:0]     loop_wide;

    assign last      = (img_size >> 1) - 32'd1;
    assign lba_base  = 32'(sd_lba) << WI;
    assign addr      = lba_base | 32'(word_idx);
    assign past_last = (lba_base + SEC32) > last;
    assign fifo_ok   = 32'(audio_fifo_usedw) < HIGH32;
    assign trig_code = trig_stop ? P_STOP : trig_pause ? P_PAUSE : trig_play ? P_PLAY : P_NONE;
    assign pend_eff  = (trig_code > pend) ? trig_code : pend;
    // Saturate so a huge loop index cannot wrap back into the track range.
    assign loop_wide = 34'(HDR32) + {1'b0, sd_buff_dout, loop_lo, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              state <= S_IDLE;
        else if (trackmounting) state <= S_IDLE;
        else                    state <= state_next;
    end

    always_comb begin
        state_next = state;
        act        = A_NONE;
        case (state)
            S_IDLE: if (trig_play && !trig_pause && !trig_stop && !trackmissing) begin
                if (img_size < MIN_SIZE) act = A_EMPTY;
                else begin act = A_START; state_next = S_REQ; end
            end
            S_REQ, S_WAIT: begin
                if (trig_stop)                       begin act = A_STOP;    state_next = S_IDLE;   end
                else if (trig_pause)                 begin act = A_PAUSE;   state_next = S_PAUSED; end
                else if (trig_play)                  begin act = A_RESTART; state_next = S_WAIT;   end
                else if (state == S_REQ && sd_ack)   begin act = A_XFER;    state_next = S_XFER;   end
                else if (state == S_WAIT && fifo_ok) begin act = A_REQ;     state_next = S_REQ;    end
            end
            S_XFER: if (!sd_ack) begin
                if (pend_eff == P_STOP)       begin act = A_STOP;       state_next = S_IDLE;   end
                else if (pend_eff == P_PLAY)  begin act = A_RESTART;    state_next = S_WAIT;   end
                else if (sig_bad)             begin act = A_SIGBAD;     state_next = S_IDLE;   end
                else if (past_last)           begin                     state_next = S_END;    end
                else if (pend_eff == P_PAUSE) begin act = A_PAUSE_NEXT; state_next = S_PAUSED; end
                else                          begin act = A_NEXT;       state_next = S_WAIT;   end
            end
            S_END: begin
                if (repeat_in && loop_addr <= last) begin act = A_LOOP;   state_next = S_WAIT; end
                else                                begin act = A_FINISH; state_next = S_IDLE; end
            end
            S_PAUSED: begin
                if (trig_stop)       begin act = A_STOP;   state_next = S_IDLE; end
                else if (trig_play && !trig_pause) begin act = A_RESUME; state_next = S_WAIT; end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_lba <= '0; sd_rd <= 1'b0; sample_wr <= 1'b0; sample_data <= '0; audio_play <= 1'b0;
            track_end <= 1'b0; header_bad <= 1'b0; word_idx <= '0; start_addr <= HDR32;
            loop_addr <= HDR32; loop_lo <= '0; pend <= P_NONE; sig_bad <= 1'b0;
        end else if (trackmounting) begin
            sd_lba <= '0; sd_rd <= 1'b0; sample_wr <= 1'b0; sample_data <= '0; audio_play <= 1'b0;
            track_end <= 1'b0; header_bad <= 1'b0; word_idx <= '0; start_addr <= HDR32;
            loop_addr <= HDR32; loop_lo <= '0; pend <= P_NONE; sig_bad <= 1'b0;
        end else begin
            sample_wr <= 1'b0;
            track_end <= 1'b0;
            if (state == S_XFER) begin
                pend <= pend_eff;
                if (sd_buff_wr) begin
                    word_idx    <= word_idx + WI'(1);
                    sample_data <= sd_buff_dout;
                    sample_wr   <= (addr >= start_addr) && (addr <= last) && !sig_bad;
                    if (addr >= start_addr) start_addr <= HDR32;
                    if (sd_lba == '0) begin
                        if (word_idx == WI'(2)) loop_lo <= sd_buff_dout;
                        if (word_idx == WI'(3)) loop_addr <= (loop_wide[33:32] != 2'b00) ? 32'hFFFF_FFFF : loop_wide[31:0];
                        if (SIG_CHECK && ((word_idx == WI'(0) && sd_buff_dout != 16'h534D) ||
                                          (word_idx == WI'(1) && sd_buff_dout != 16'h3155))) begin
                            sig_bad    <= 1'b1;
                            header_bad <= 1'b1;
                            audio_play <= 1'b0;
                        end
                    end
                end
            end
            case (act)
                A_START:      begin sd_lba <= '0; start_addr <= HDR32; audio_play <= 1'b1; sd_rd <= 1'b1;
                                    header_bad <= 1'b0; pend <= P_NONE; sig_bad <= 1'b0; end
                A_EMPTY:      track_end <= 1'b1;
                A_REQ:        sd_rd <= 1'b1;
                A_XFER:       begin sd_rd <= 1'b0; word_idx <= '0; pend <= P_NONE; end
                A_RESTART:    begin sd_rd <= 1'b0; sd_lba <= '0; start_addr <= HDR32; pend <= P_NONE;
                                    sig_bad <= 1'b0; audio_play <= 1'b1; end
                A_STOP:       begin sd_rd <= 1'b0; audio_play <= 1'b0; pend <= P_NONE; end
                A_PAUSE:      begin sd_rd <= 1'b0; audio_play <= 1'b0; end
                A_PAUSE_NEXT: begin sd_lba <= sd_lba + LBA_W'(1); audio_play <= 1'b0; pend <= P_NONE; end
                A_NEXT:       sd_lba <= sd_lba + LBA_W'(1);
                A_RESUME:     audio_play <= 1'b1;
                A_LOOP:       begin sd_lba <= LBA_W'(loop_addr >> WI); start_addr <= loop_addr; end
                A_FINISH:     begin audio_play <= 1'b0; track_end <= 1'b1; header_bad <= repeat_in && (loop_addr > last); end
                A_SIGBAD:     begin audio_play <= 1'b0; pend <= P_NONE; end
                default:      ;
            endcase
        end
    end
endmodule

// File: tb/tb_msu_audio_streamer.sv
// Directed bench for msu_audio_streamer: a sector-serving SD model plus a table of whole-track scenarios and corner sequences.
module tb_msu_audio_streamer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] img_size = 32'd0;
    logic        trackmounting = 1'b0, trackmissing = 1'b0;
    logic        trig_play = 1'b0, trig_pause = 1'b0, trig_stop = 1'b0, repeat_in = 1'b0;
    logic        sd_ack, sd_buff_wr;
    logic [15:0] sd_buff_dout;
    logic [11:0] audio_fifo_usedw = 12'd0;
    logic [20:0] sd_lba;
    logic        sd_rd, sample_wr, audio_play, track_end, header_bad;
    logic [15:0] sample_data;

    msu_audio_streamer dut (
        .clk(clk), .reset(reset), .img_size(img_size), .trackmounting(trackmounting),
        .trackmissing(trackmissing), .trig_play(trig_play), .trig_pause(trig_pause),
        .trig_stop(trig_stop), .repeat_in(repeat_in), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
        .sd_buff_dout(sd_buff_dout), .audio_fifo_usedw(audio_fifo_usedw), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sample_wr(sample_wr), .sample_data(sample_data), .audio_play(audio_play),
        .track_end(track_end), .header_bad(header_bad)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int wr_count, te_count, seq_err, req_count, probe_idx, sec3_wr;
    logic [15:0] probe_data;
    logic [31:0] cur_loop, cur_last;
    longint      cur_loop_addr, exp_next;
    logic        cur_rep;
    int          mdl_lba, mdl_w;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [15:0] word_at(input int a);
        logic [31:0] av;
        av = a;
        case (a)
            0: return 16'h534D;
            1: return 16'h3155;
            2: return cur_loop[15:0];
            3: return cur_loop[31:16];
            default: return av[15:0];
        endcase
    endfunction

    // SD model: serves one full sector per sd_rd request.
    initial begin
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_dout = 16'd0; mdl_lba = -1; mdl_w = 0;
        forever begin
            @(negedge clk);
            if (sd_rd && !sd_ack && !reset) begin
                mdl_lba = int'(sd_lba);
                req_count++;
                @(negedge clk) sd_ack = 1'b1;
                for (int w = 0; w < 256; w++) begin
                    @(negedge clk);
                    sd_buff_wr = 1'b1;
                    sd_buff_dout = word_at(mdl_lba * 256 + w);
                    mdl_w = w;
                end
                @(negedge clk) sd_buff_wr = 1'b0;
                @(negedge clk) sd_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_wr) begin
            wr_count++;
            if ({16'd0, sample_data} !== exp_next[31:0] && exp_next < 65536) seq_err++;
            if (wr_count == probe_idx) probe_data = sample_data;
            if (sample_data >= 16'd768 && sample_data < 16'd1024) sec3_wr++;
            if (exp_next == longint'(cur_last) && cur_rep && cur_loop_addr <= longint'(cur_last)) exp_next = cur_loop_addr;
            else exp_next++;
        end
        if (track_end) te_count++;
    end

    task automatic pulse(input int which);
        @(negedge clk);
        trig_stop = (which == 3); trig_pause = (which == 2); trig_play = (which == 1);
        @(negedge clk);
        trig_stop = 1'b0; trig_pause = 1'b0; trig_play = 1'b0;
    endtask

    task automatic setup(input logic [31:0] img, input logic rep, input logic [31:0] loopv);
        img_size = img; repeat_in = rep; cur_loop = loopv; cur_rep = rep;
        cur_last = (img >> 1) - 1;
        cur_loop_addr = 4 + 2 * longint'(loopv);
        wr_count = 0; te_count = 0; seq_err = 0; req_count = 0; sec3_wr = 0; exp_next = 4;
        probe_data = 16'hDEAD;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (sd_ack && n < 1000) begin @(negedge clk); n++; end
        check("settle_timeout", (n >= 1000), 0);
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] img; logic rep; logic [31:0] loopv; int stop_at; int probe;
        int exp_wr; logic [15:0] exp_probe; int exp_te; logic exp_hb; logic exp_play; int exp_req;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n;
        logic got;
        vecs[0] = '{32'd1024, 1'b0, 32'd0,          0,   1,   508, 16'h0004, 1, 1'b0, 1'b1, 2};
        vecs[1] = '{32'd1000, 1'b1, 32'd130,        732, 497, 732, 16'h0108, 0, 1'b0, 1'b1, 3};
        vecs[2] = '{32'd1000, 1'b1, 32'hFFFF_FFFF,  0,   496, 496, 16'h01F3, 1, 1'b1, 1'b1, 2};
        vecs[3] = '{32'd1000, 1'b0, 32'd130,        0,   496, 496, 16'h01F3, 1, 1'b0, 1'b1, 2};
        vecs[4] = '{32'd8,    1'b0, 32'd0,          0,   0,   0,   16'hDEAD, 1, 1'b0, 1'b0, 0};
        vecs[5] = '{32'd10,   1'b0, 32'd0,          0,   1,   1,   16'h0004, 1, 1'b0, 1'b1, 1};
        vecs[6] = '{32'd1000, 1'b1, 32'd200,        592, 497, 592, 16'h0194, 0, 1'b0, 1'b1, 3};
        setup(32'd1024, 1'b0, 32'd0);
        probe_idx = 0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {11'd0, sd_lba, sd_rd, sample_wr, audio_play, track_end, header_bad}, 0);
        reset = 1'b0;
        @(negedge clk);

        trackmissing = 1'b1;
        pulse(1);
        repeat (5) @(negedge clk);
        check("missing_no_play", {sd_rd, audio_play}, 0);
        trackmissing = 1'b0;

        for (int i = 0; i < 7; i++) begin
            setup(vecs[i].img, vecs[i].rep, vecs[i].loopv);
            probe_idx = vecs[i].probe;
            pulse(1);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_play", i), audio_play, vecs[i].exp_play);
            n = 0;
            while (!(te_count > 0 || (vecs[i].stop_at != 0 && wr_count >= vecs[i].stop_at)) && n < 20000) begin
                @(negedge clk); n++;
            end
            check($sformatf("v%0d_timeout", i), (n >= 20000), 0);
            if (vecs[i].stop_at != 0) pulse(3);
            settle();
            check($sformatf("v%0d_writes", i), wr_count, vecs[i].exp_wr);
            check($sformatf("v%0d_seq_err", i), seq_err, 0);
            check($sformatf("v%0d_track_end", i), te_count, vecs[i].exp_te);
            check($sformatf("v%0d_header_bad", i), header_bad, vecs[i].exp_hb);
            check($sformatf("v%0d_play_end", i), audio_play, 0);
            check($sformatf("v%0d_probe", i), probe_data, vecs[i].exp_probe);
            check($sformatf("v%0d_requests", i), req_count, vecs[i].exp_req);
        end

        // FIFO-level gating of sector requests.
        setup(32'd1024, 1'b0, 32'd0);
        audio_fifo_usedw = 12'd1800;
        pulse(1);
        n = 0;
        while (!sd_ack && n < 100) begin @(negedge clk); n++; end
        while (sd_ack && n < 600) begin @(negedge clk); n++; end
        check("usedw_xfer_timeout", (n >= 600), 0);
        got = 1'b0;
        repeat (40) begin @(negedge clk); if (sd_rd) got = 1'b1; end
        check("usedw_hold_no_rd", got, 0);
        audio_fifo_usedw = 12'd1000;
        got = 1'b0;
        repeat (2) begin @(negedge clk); if (sd_rd) got = 1'b1; end
        check("usedw_release_rd", got, 1);
        check("usedw_release_lba", sd_lba, 1);
        n = 0;
        while (te_count == 0 && n < 2000) begin @(negedge clk); n++; end
        settle();
        check("usedw_writes", wr_count, 508);
        audio_fifo_usedw = 12'd0;

        // Pause mid-sector 3: sector completes, resume at LBA 4.
        setup(32'd4096, 1'b0, 32'd0);
        pulse(1);
        n = 0;
        while (!(sd_ack && mdl_lba == 3 && mdl_w >= 100) && n < 5000) begin @(negedge clk); n++; end
        check("pause_reach_timeout", (n >= 5000), 0);
        pulse(2);
        settle();
        check("pause_sector_writes", sec3_wr, 256);
        check("pause_play_off", audio_play, 0);
        got = 1'b0;
        repeat (30) begin @(negedge clk); if (sd_rd) got = 1'b1; end
        check("pause_no_rd", got, 0);
        pulse(1);
        n = 0;
        while (!sd_rd && n < 50) begin @(negedge clk); n++; end
        check("resume_rd", sd_rd, 1);
        check("resume_lba", sd_lba, 4);
        check("resume_play", audio_play, 1);
        pulse(3);
        settle();
        check("stop_play_off", audio_play, 0);

        // Asynchronous reset in the middle of a transfer.
        setup(32'd1024, 1'b0, 32'd0);
        pulse(1);
        n = 0;
        while (!(sd_ack && mdl_lba == 1 && mdl_w >= 50) && n < 2000) begin @(negedge clk); n++; end
        check("rst_reach_timeout", (n >= 2000), 0);
        #3 reset = 1'b1;
        #1 check("rst_async_outputs", {11'd0, sd_lba, sd_rd, sample_wr, audio_play, track_end, header_bad}, 0);
        @(negedge clk) reset = 1'b0;
        wr_count = 0;
        settle();
        repeat (20) @(negedge clk);
        check("rst_no_writes", wr_count, 0);
        check("rst_no_rd", sd_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
